oclib_apb_arbiter: RTL

OCLIB_APB_ARBITER -- requirements
Module: oclib_apb_arbiter

---
 rtl/oclib_apb_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/oclib_apb_arbiter.sv
// -----------------------------------------------------------------------------
// oclib_apb_arbiter
//
// Shares one downstream APB completer among Requesters upstream APB masters.
// Each transaction is granted to a single master, chosen round-robin from the
// masters holding select. The granted master's write/address/wdata are
// captured at grant. The downstream transfer is replayed as a standard
// SETUP/ACCESS sequence. The completer's response is returned to that master
// as a one-cycle ready pulse, one cycle after the downstream ready is sampled.
// A one-cycle release state follows every transfer. It gives the master time
// to drop select, so the same transfer cannot be granted twice.
//
// Ports
//   clock     in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   apbIn     in   ApbType   [Requesters]  upstream requests
//   apbInFb   out  ApbFbType [Requesters]  upstream responses
//   apbOut    out  ApbType                 shared downstream request
//   apbOutFb  in   ApbFbType               shared downstream response
//
// Build option
//   OCLIB_APB_ARBITER_TIMEOUT_EN : when defined, an access that sees no
//   downstream ready for TimeoutCycles cycles is aborted. The master gets
//   ready=1, error=1 and rdata=0. When undefined, the access waits forever
//   and TimeoutCycles has no effect.
//
// The default request/response structs live in oclib_pkg below.
// -----------------------------------------------------------------------------

package oclib_pkg;

  typedef struct packed {
    logic        select;
    logic        enable;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } apb_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } apb_fb_s;

endpackage

module oclib_apb_arbiter #(
  parameter int  Requesters    = 2,
  parameter type ApbType       = oclib_pkg::apb_s,
  parameter type ApbFbType     = oclib_pkg::apb_fb_s,
  parameter int  TimeoutCycles = 256
) (
  input  logic     clock,
  input  logic     reset,
  input  ApbType   apbIn   [Requesters],
  output ApbFbType apbInFb [Requesters],
  output ApbType   apbOut,
  input  ApbFbType apbOutFb
);

  localparam int IdxW = $clog2(Requesters);

  if (Requesters < 2 || Requesters > 8 || TimeoutCycles < 1) begin : g_bad_param
    $error("oclib_apb_arbiter: Requesters must be 2..8 and TimeoutCycles >= 1");
  end

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StAccess  = 2'd2,
    StRelease = 2'd3
  } state_e;

  state_e          state;
  state_e          state_next;

  // Control: round-robin pointer doubles as the current grant index.
  logic [IdxW-1:0] last_grant;
  logic [IdxW-1:0] pick;
  logic            pick_vld;
  int              cand;
  logic [IdxW-1:0] cand_idx;

  // Data captured at grant; never reset because it is only visible while
  // a grant is active.
  ApbType          cap_req;

  // Response returned to the granted master, one cycle after completion.
  ApbFbType        rsp_p1;

  logic            access_done;
  logic            timeout_hit;

  // ---------------------------------------------------------------------------
  // Round-robin selection: the first pending index strictly after last_grant,
  // wrapping from Requesters-1 to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= Requesters; k++) begin
      cand     = (int'(last_grant) + k) % Requesters;
      cand_idx = IdxW'(cand);
      if (!pick_vld && apbIn[cand_idx].select) begin
        pick     = cand_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign access_done = (state == StAccess) && apbOutFb.ready;

`ifdef OCLIB_APB_ARBITER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] to_cnt;

  // The count holds the number of access cycles already spent without ready.
  // The cycle that would reach TimeoutCycles is the abort cycle.
  assign timeout_hit = (state == StAccess) && !apbOutFb.ready &&
                       (to_cnt == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == StSetup) begin
      to_cnt <= '0;
    end else if ((state == StAccess) && !apbOutFb.ready && !timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      StIdle:    if (pick_vld) state_next = StSetup;
      StSetup:   state_next = StAccess;
      StAccess:  if (access_done || timeout_hit) state_next = StRelease;
      StRelease: state_next = StIdle;
      default:   state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping and response register (control, reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= IdxW'(Requesters - 1);
      rsp_p1     <= '0;
    end else begin
      rsp_p1.ready <= 1'b0;
      if ((state == StIdle) && pick_vld) begin
        last_grant <= pick;
        rsp_p1     <= '0;
      end
      if (access_done) begin
        rsp_p1.ready <= 1'b1;
        rsp_p1.error <= apbOutFb.error;
        rsp_p1.rdata <= apbOutFb.rdata;
      end else if (timeout_hit) begin
        rsp_p1.ready <= 1'b1;
        rsp_p1.error <= 1'b1;
        rsp_p1.rdata <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture at grant (data, no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if ((state == StIdle) && pick_vld) begin
      cap_req <= apbIn[pick];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    apbOut = '0;
    if ((state == StSetup) || (state == StAccess)) begin
      apbOut        = cap_req;
      apbOut.select = 1'b1;
      apbOut.enable = (state == StAccess);
    end
  end

  // Only the current (or most recent) grantee sees the response register.
  always_comb begin
    for (int j = 0; j < Requesters; j++) begin
      apbInFb[j] = '0;
      if (IdxW'(j) == last_grant) begin
        apbInFb[j] = rsp_p1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(apbOut.enable && !apbOut.select))
        else $error("oclib_apb_arbiter: enable asserted without select");
    end
  end

endmodule
